// File: rtl/a5_1_pixel_decryptor.sv
`timescale 1ns/1ps
// a5_1_pixel_decryptor
// Receive-side A5/1 keystream engine for the encrypted image link.
// Three LFSRs (R1 19b, R2 22b, R3 23b) are loaded with the 64-bit session key
// and the 22-bit frame number, warmed up with majority clocking, and then
// produce keystream bytes that are XORed onto incoming cipher pixels.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   start                   1-cycle pulse; latches keys and restarts setup (IDLE/RUN only)
//   secret_key, public_key  Kc (64b) and frame number (22b), bit 0 loaded first
//   busy                    high during key / frame / warm-up setup
//   cipher_in/valid/ready   encrypted byte input stream
//   plain_out/valid/ready   decrypted byte output stream
//   dbg_state               current FSM state (IDLE=0 KEY=1 FRAME=2 WARM=3 RUN=4)
//
// Handshake: a byte moves on any rising edge where valid && ready. A producer
// holds its data stable while valid is high and ready is low; cipher_ready is
// never a function of cipher_valid.
module a5_1_pixel_decryptor #(
    parameter int WARMUP_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] secret_key,
    input  logic [21:0] public_key,
    output logic        busy,
    input  logic [7:0]  cipher_in,
    input  logic        cipher_valid,
    output logic        cipher_ready,
    output logic [7:0]  plain_out,
    output logic        plain_valid,
    input  logic        plain_ready,
    output logic [2:0]  dbg_state
);

    localparam int SETUP_MAX = (WARMUP_CYCLES > 64) ? WARMUP_CYCLES : 64;
    localparam int CNT_W     = $clog2(SETUP_MAX) + 1;
    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(63);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(21);
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_FRAME = 3'd2,
        S_WARM  = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic [63:0] sk_q;
    logic [21:0] pk_q;
    logic [7:0]  ks_byte;
    logic [2:0]  ks_cnt;
    logic        ks_full;

    logic        start_ok;
    logic        accept;
    logic        maj;
    logic        load_bit;
    logic        ks_bit;
    logic [18:0] r1_step, r1_maj;
    logic [21:0] r2_step, r2_maj;
    logic [22:0] r3_step, r3_maj;

    // start is only honoured when no setup sequence is in flight.
    assign start_ok = start && (state == S_IDLE || state == S_RUN);
    assign busy     = (state == S_KEY) || (state == S_FRAME) || (state == S_WARM);
    assign cipher_ready = (state == S_RUN) && ks_full && (!plain_valid || plain_ready);
    assign accept   = cipher_valid && cipher_ready;
    assign dbg_state = state;

    // Plain shift of each register; feedback enters bit 0.
    assign r1_step = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18]};
    assign r2_step = {r2[20:0], r2[20] ^ r2[21]};
    assign r3_step = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22]};

    // Majority clocking: a register advances only if its clock bit agrees
    // with the majority of the three clock bits.
    assign maj    = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    assign r1_maj = (r1[8]  == maj) ? r1_step : r1;
    assign r2_maj = (r2[10] == maj) ? r2_step : r2;
    assign r3_maj = (r3[10] == maj) ? r3_step : r3;
    assign ks_bit = r1_maj[18] ^ r2_maj[21] ^ r3_maj[22];

    // Key bit injected during the current load step (cnt is the step index).
    assign load_bit = (state == S_KEY) ? sk_q[cnt[5:0]] : pk_q[cnt[4:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_KEY;
                    cnt_next   = '0;
                end
            end
            S_KEY: begin
                if (cnt == KEY_LAST) begin
                    state_next = S_FRAME;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_FRAME: begin
                if (cnt == FRAME_LAST) begin
                    state_next = S_WARM;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_WARM: begin
                if (cnt == WARM_LAST) begin
                    state_next = S_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (start) begin
                    state_next = S_KEY;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // LFSRs and keystream byte buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r1      <= '0;
            r2      <= '0;
            r3      <= '0;
            sk_q    <= '0;
            pk_q    <= '0;
            ks_byte <= '0;
            ks_cnt  <= '0;
            ks_full <= 1'b0;
        end else if (start_ok) begin
            sk_q    <= secret_key;
            pk_q    <= public_key;
            r1      <= '0;
            r2      <= '0;
            r3      <= '0;
            ks_byte <= '0;
            ks_cnt  <= '0;
            ks_full <= 1'b0;
        end else begin
            case (state)
                S_KEY, S_FRAME: begin
                    r1 <= r1_step ^ {18'd0, load_bit};
                    r2 <= r2_step ^ {21'd0, load_bit};
                    r3 <= r3_step ^ {22'd0, load_bit};
                end
                S_WARM: begin
                    r1 <= r1_maj;
                    r2 <= r2_maj;
                    r3 <= r3_maj;
                end
                S_RUN: begin
                    if (!ks_full) begin
                        // First bit of a byte ends up in bit 7.
                        r1      <= r1_maj;
                        r2      <= r2_maj;
                        r3      <= r3_maj;
                        ks_byte <= {ks_byte[6:0], ks_bit};
                        ks_cnt  <= ks_cnt + 3'd1;
                        if (ks_cnt == 3'd7) begin
                            ks_full <= 1'b1;
                        end
                    end else if (accept) begin
                        ks_full <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output register: survives restarts so a pending byte is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            plain_out   <= 8'h00;
            plain_valid <= 1'b0;
        end else if (accept) begin
            plain_out   <= cipher_in ^ ks_byte;
            plain_valid <= 1'b1;
        end else if (plain_ready) begin
            plain_valid <= 1'b0;
        end
    end

endmodule
